// File: rtl/maxfinder_pkg.sv
// maxfinder_pkg
// Definitions shared by the max-finder and the memory loader: default
// datapath widths and the 3-bit controller state encodings.
package maxfinder_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 4;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_DATA  = 3'd1;
   localparam logic [2:0] ST_WRITE      = 3'd2;
   localparam logic [2:0] ST_CHECK_LAST = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;

endpackage

// File: rtl/mem_loader_ctrl.sv
// mem_loader_ctrl
// Moore FSM sequencing a RAM fill. It owns no datapath registers; it only
// issues enables to the MAR/MDR/count registers held in mem_loader.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            begin a fill (acts only in IDLE or DONE)
//   in_valid         stream source has a word
//   mar_eq_maxaddr   MAR currently holds the last address
//   en_mar, sel_mar  MAR load enable; sel_mar=0 clears, 1 increments
//   en_mdr           capture in_data into MDR
//   en_cnt           word counter enable (uses sel_mar as clear/increment)
//   mem_we           RAM write strobe
//   in_ready         loader accepts a word this cycle
//   busy, done       status flags
module mem_loader_ctrl (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic in_valid,
   input  logic mar_eq_maxaddr,
   output logic en_mar,
   output logic sel_mar,
   output logic en_mdr,
   output logic en_cnt,
   output logic mem_we,
   output logic in_ready,
   output logic busy,
   output logic done
);

   import maxfinder_pkg::*;

   logic [2:0] state;
   logic [2:0] next_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // in_ready, mem_we, busy and done depend on the state alone; only the
   // internal register enables look at start/in_valid/mar_eq_maxaddr.
   always_comb begin
      next_state = state;
      en_mar     = 1'b0;
      sel_mar    = 1'b0;
      en_mdr     = 1'b0;
      en_cnt     = 1'b0;
      mem_we     = 1'b0;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               en_mar     = 1'b1;
               en_cnt     = 1'b1;
               next_state = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            // in_ready is unconditionally high here, so in_valid alone
            // completes the handshake.
            if (in_valid) begin
               en_mdr     = 1'b1;
               next_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_we     = 1'b1;
            busy       = 1'b1;
            en_cnt     = 1'b1;
            sel_mar    = 1'b1;
            next_state = ST_CHECK_LAST;
         end
         ST_CHECK_LAST: begin
            busy = 1'b1;
            // Comparing before incrementing keeps MAR from ever wrapping.
            if (mar_eq_maxaddr) begin
               next_state = ST_DONE;
            end else begin
               en_mar     = 1'b1;
               sel_mar    = 1'b1;
               next_state = ST_WAIT_DATA;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               en_mar     = 1'b1;
               en_cnt     = 1'b1;
               next_state = ST_WAIT_DATA;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/mem_loader.sv
// mem_loader
// Fills a single-port RAM at addresses 0..MAX_ADDR from a valid/ready word
// stream, through a registered MAR/MDR pair. Write-side counterpart of the
// max-finder.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        begin a fill (ignored while busy)
//   in_data      stream word; in_valid qualifies it, in_ready accepts it
//   mem_addr     RAM write address (MAR)
//   mem_wdata    RAM write data (MDR)
//   mem_we       one-cycle write strobe per word
//   busy         fill in progress
//   done         last address written; held until the next start
//   word_count   words written since the last start
module mem_loader #(
   parameter int DATA_W   = maxfinder_pkg::DEFAULT_DATA_W,
   parameter int ADDR_W   = maxfinder_pkg::DEFAULT_ADDR_W,
   parameter int MAX_ADDR = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count
);

   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic [ADDR_W:0]   cnt;
   logic              en_mar;
   logic              sel_mar;
   logic              en_mdr;
   logic              en_cnt;
   logic              mar_eq_maxaddr;

   assign mar_eq_maxaddr = (mar == ADDR_W'(MAX_ADDR));

   mem_loader_ctrl u_ctrl (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .in_valid       (in_valid),
      .mar_eq_maxaddr (mar_eq_maxaddr),
      .en_mar         (en_mar),
      .sel_mar        (sel_mar),
      .en_mdr         (en_mdr),
      .en_cnt         (en_cnt),
      .mem_we         (mem_we),
      .in_ready       (in_ready),
      .busy           (busy),
      .done           (done)
   );

   // sel_mar=0 is the "start of fill" clear shared by MAR and the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         mar <= '0;
         mdr <= '0;
         cnt <= '0;
      end else begin
         if (en_mar) begin
            mar <= sel_mar ? mar + ADDR_W'(1) : '0;
         end
         if (en_mdr) begin
            mdr <= in_data;
         end
         if (en_cnt) begin
            cnt <= sel_mar ? cnt + (ADDR_W + 1)'(1) : '0;
         end
      end
   end

   assign mem_addr   = mar;
   assign mem_wdata  = mdr;
   assign word_count = cnt;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader
// Directed bench for mem_loader. Two instances share the stream inputs: the
// main one (MAX_ADDR=15) and a short one (MAX_ADDR=3). "sel" picks which
// instance gets start and which one the view signals observe; the other sits
// in IDLE or DONE where in_valid is ignored.
module tb_mem_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       sel;
   logic [7:0] in_data;
   logic       in_valid;

   logic       start_a, start_b;
   logic       ready_a, ready_b, we_a, we_b, busy_a, busy_b, done_a, done_b;
   logic [3:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic [4:0] count_a, count_b;

   logic       v_ready, v_we, v_busy, v_done;
   logic [3:0] v_addr;
   logic [7:0] v_wdata;
   logic [4:0] v_count;

   logic [7:0] ram_a [16];
   logic [7:0] ram_b [16];
   int         wr_cnt_a = 0;
   int         wr_cnt_b = 0;

   int         compared = 0;
   int         mismatched = 0;

   always #5 clk = ~clk;

   assign start_a = start && !sel;
   assign start_b = start && sel;

   assign v_ready = sel ? ready_b : ready_a;
   assign v_we    = sel ? we_b    : we_a;
   assign v_busy  = sel ? busy_b  : busy_a;
   assign v_done  = sel ? done_b  : done_a;
   assign v_addr  = sel ? addr_b  : addr_a;
   assign v_wdata = sel ? wdata_b : wdata_a;
   assign v_count = sel ? count_b : count_a;

   mem_loader #(.DATA_W(8), .ADDR_W(4), .MAX_ADDR(15)) dut (
      .clk(clk), .reset(reset), .start(start_a), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ready_a), .mem_addr(addr_a),
      .mem_wdata(wdata_a), .mem_we(we_a), .busy(busy_a), .done(done_a),
      .word_count(count_a)
   );

   mem_loader #(.DATA_W(8), .ADDR_W(4), .MAX_ADDR(3)) dut3 (
      .clk(clk), .reset(reset), .start(start_b), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ready_b), .mem_addr(addr_b),
      .mem_wdata(wdata_b), .mem_we(we_b), .busy(busy_b), .done(done_b),
      .word_count(count_b)
   );

   // RAM models: mem_we is a full-cycle pulse, so the falling edge sees it once.
   always @(negedge clk) begin
      if (we_a === 1'b1) begin
         ram_a[addr_a] <= wdata_a;
         wr_cnt_a      <= wr_cnt_a + 1;
      end
      if (we_b === 1'b1) begin
         ram_b[addr_b] <= wdata_b;
         wr_cnt_b      <= wr_cnt_b + 1;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: observed timeout, expected $finish");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word after 'gap' idle cycles, then check the WRITE and
   // CHECK_LAST cycles that follow the handshake. Returns during CHECK_LAST.
   task automatic applyStimulus(input logic [7:0] data, input int addr,
                                input int gap, input bit hold_valid,
                                input bit poke_start);
      bit ready_seen;
      bit got;
      start = poke_start;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) tick();
         checkOutput("gap_no_we", {31'd0, v_we}, 32'd0);
      end
      in_valid = 1'b1;
      in_data  = data;
      got      = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         ready_seen = v_ready;
         tick();
         if (ready_seen) got = 1'b1;
      end
      if (!got) checkOutput("handshake_timeout", 32'd0, 32'd1);
      in_valid = hold_valid;
      checkOutput("write_we", {31'd0, v_we}, 32'd1);
      checkOutput("write_addr", {28'd0, v_addr}, addr);
      checkOutput("write_data", {24'd0, v_wdata}, {24'd0, data});
      checkOutput("write_ready", {31'd0, v_ready}, 32'd0);
      tick();
      start = 1'b0;
      checkOutput("check_ready", {31'd0, v_ready}, 32'd0);
      checkOutput("check_we", {31'd0, v_we}, 32'd0);
   endtask

   logic [7:0] int_data [16];
   int         gaps [16];
   int         saved_wr;
   logic [7:0] max_val;
   int         max_idx;

   initial begin
      int_data = '{8'h03, 8'h7F, 8'h12, 8'h45, 8'h00, 8'h7E, 8'h33, 8'h21,
                   8'h6A, 8'h09, 8'h5C, 8'h11, 8'h77, 8'h01, 8'h40, 8'h2B};
      gaps     = '{3, 0, 7, 1, 5, 2, 6, 4, 0, 2, 7, 3, 1, 6, 5, 0};
      sel      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reset    = 1'b1;

      // Reset state
      repeat (2) tick();
      checkOutput("rst_ready", {31'd0, v_ready}, 32'd0);
      checkOutput("rst_we", {31'd0, v_we}, 32'd0);
      checkOutput("rst_busy", {31'd0, v_busy}, 32'd0);
      checkOutput("rst_done", {31'd0, v_done}, 32'd0);
      checkOutput("rst_addr", {28'd0, v_addr}, 32'd0);
      checkOutput("rst_wdata", {24'd0, v_wdata}, 32'd0);
      checkOutput("rst_count", {27'd0, v_count}, 32'd0);
      checkOutput("rst_b_busy", {31'd0, busy_b}, 32'd0);
      reset = 1'b0;
      repeat (5) tick();
      checkOutput("idle_busy", {31'd0, v_busy}, 32'd0);
      checkOutput("idle_ready", {31'd0, v_ready}, 32'd0);
      checkOutput("idle_writes", wr_cnt_a, 32'd0);

      // Fill 0x10..0x1F, in_valid held high; start+valid together first
      $display("[TB] fill with in_valid held high");
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      tick();
      start = 1'b0;
      checkOutput("start_busy", {31'd0, v_busy}, 32'd1);
      checkOutput("start_ready", {31'd0, v_ready}, 32'd1);
      checkOutput("start_count", {27'd0, v_count}, 32'd0);
      checkOutput("start_no_we", {31'd0, v_we}, 32'd0);
      for (int i = 0; i < 16; i++) applyStimulus(8'h10 + 8'(i), i, 0, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      checkOutput("fill1_done", {31'd0, v_done}, 32'd1);
      checkOutput("fill1_busy", {31'd0, v_busy}, 32'd0);
      checkOutput("fill1_count", {27'd0, v_count}, 32'd16);
      checkOutput("fill1_addr", {28'd0, v_addr}, 32'd15);
      checkOutput("fill1_ready", {31'd0, v_ready}, 32'd0);
      checkOutput("fill1_writes", wr_cnt_a, 32'd16);
      for (int i = 0; i < 16; i++) checkOutput("fill1_ram", {24'd0, ram_a[i]}, 32'h10 + i);
      repeat (3) tick();
      checkOutput("fill1_done_hold", {31'd0, v_done}, 32'd1);

      // Same data with idle gaps; model RAM cleared first
      $display("[TB] fill with in_valid gaps");
      for (int i = 0; i < 16; i++) ram_a[i] = 8'hXX;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("restart_done", {31'd0, v_done}, 32'd0);
      checkOutput("restart_count", {27'd0, v_count}, 32'd0);
      checkOutput("restart_addr", {28'd0, v_addr}, 32'd0);
      for (int i = 0; i < 16; i++) applyStimulus(8'h10 + 8'(i), i, gaps[i], 1'b0, 1'b0);
      tick();
      checkOutput("fill2_done", {31'd0, v_done}, 32'd1);
      checkOutput("fill2_writes", wr_cnt_a, 32'd32);
      for (int i = 0; i < 16; i++) checkOutput("fill2_ram", {24'd0, ram_a[i]}, 32'h10 + i);

      // Integration: scan the filled RAM for its maximum
      $display("[TB] integration fill and max scan");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 16; i++) applyStimulus(int_data[i], i, i % 3, 1'b0, 1'b0);
      tick();
      checkOutput("int_done", {31'd0, v_done}, 32'd1);
      max_val = 8'h00;
      max_idx = 0;
      for (int i = 0; i < 16; i++) begin
         if (ram_a[i] > max_val) begin
            max_val = ram_a[i];
            max_idx = i;
         end
      end
      checkOutput("int_max_val", {24'd0, max_val}, 32'h7F);
      checkOutput("int_max_idx", max_idx, 32'd1);

      // Reset in WAIT_DATA after the 5th write
      $display("[TB] reset mid-fill");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i), i, 0, 1'b0, 1'b0);
      tick();
      checkOutput("mid_wait_ready", {31'd0, v_ready}, 32'd1);
      saved_wr = wr_cnt_a;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
      checkOutput("mid_rst_ready", {31'd0, v_ready}, 32'd0);
      checkOutput("mid_rst_we", {31'd0, v_we}, 32'd0);
      checkOutput("mid_rst_busy", {31'd0, v_busy}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, v_done}, 32'd0);
      checkOutput("mid_rst_addr", {28'd0, v_addr}, 32'd0);
      checkOutput("mid_rst_wdata", {24'd0, v_wdata}, 32'd0);
      checkOutput("mid_rst_count", {27'd0, v_count}, 32'd0);
      tick();
      reset = 1'b0;
      repeat (4) tick();
      in_valid = 1'b0;
      checkOutput("mid_rst_no_writes", wr_cnt_a, saved_wr);
      checkOutput("mid_rst_idle_ready", {31'd0, v_ready}, 32'd0);
      checkOutput("mid_rst_ram4", {24'd0, ram_a[4]}, 32'hC4);

      // MAX_ADDR=3 instance: start poked while busy, then a restart from DONE
      $display("[TB] short fill with start pulses while busy");
      sel   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(8'hA0 + 8'(i), i, 1, 1'b0, 1'b1);
      tick();
      checkOutput("short_done", {31'd0, v_done}, 32'd1);
      checkOutput("short_count", {27'd0, v_count}, 32'd4);
      checkOutput("short_addr", {28'd0, v_addr}, 32'd3);
      checkOutput("short_writes", wr_cnt_b, 32'd4);
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      checkOutput("short_done_hold", {31'd0, v_done}, 32'd1);
      checkOutput("short_hold_writes", wr_cnt_b, 32'd4);
      for (int i = 0; i < 4; i++) checkOutput("short_ram1", {24'd0, ram_b[i]}, 32'hA0 + i);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("short_restart_done", {31'd0, v_done}, 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(8'hB0 + 8'(i), i, 0, 1'b0, 1'b0);
      tick();
      checkOutput("short2_done", {31'd0, v_done}, 32'd1);
      checkOutput("short2_writes", wr_cnt_b, 32'd8);
      for (int i = 0; i < 4; i++) checkOutput("short_ram2", {24'd0, ram_b[i]}, 32'hB0 + i);
      checkOutput("short_a_untouched", wr_cnt_a, saved_wr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Memory-fill controller plus datapath: the write-side counterpart of the max-finder controller, which reads memory.
- On `start`, it accepts a stream of words over a valid/ready handshake and writes them to a single-port RAM at sequential addresses 0..MAX_ADDR, through an internal MAR/MDR pair.
- It signals `done` when the last address has been written; the RAM is then ready for the max-finder to scan.
- Sits between the test/host stream source and the RAM write port.

Parameters:
- DATA_W, 8, width of data words and of the RAM data port
- ADDR_W, 4, width of the RAM address (MAR width)
- MAX_ADDR, 15, last address written; must satisfy MAX_ADDR <= 2^ADDR_W - 1

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a fill; sampled only in IDLE or DONE
- in_data  input  DATA_W  stream data word
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader can accept a word this cycle
- mem_addr  output  ADDR_W  RAM write address (MAR)
- mem_wdata  output  DATA_W  RAM write data (MDR)
- mem_we  output  1  RAM write enable, one cycle per word
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  fill complete; held high in DONE
- word_count  output  ADDR_W+1  words written since the last start

Behaviour:

Reset:
- state=IDLE; mem_addr=0, mem_wdata=0, word_count=0.
- in_ready=0, mem_we=0, busy=0, done=0.
- Reset during any state aborts the fill immediately. Partial RAM contents are left as written; no further writes occur.

Structure:
- Moore FSM with registered MAR, MDR and count.
- Control outputs (in_ready, mem_we, busy, done) are decoded combinationally from the state only, never from inputs.
- States: IDLE, WAIT_DATA, WRITE, CHECK_LAST, DONE.

IDLE:
- If start: MAR<=0, word_count<=0, go to WAIT_DATA.
- Else stay.

WAIT_DATA:
- in_ready=1.
- On in_valid && in_ready: MDR<=in_data, go to WRITE.
- Else stay; there is no timeout.

WRITE:
- mem_we=1, with mem_addr=MAR and mem_wdata=MDR stable for the whole cycle.
- word_count<=word_count+1, go to CHECK_LAST.

CHECK_LAST:
- If MAR==MAX_ADDR: go to DONE; MAR is not incremented.
- Else: MAR<=MAR+1, go to WAIT_DATA.
- Compare-before-increment means MAR never wraps, even when MAX_ADDR=2^ADDR_W-1.

DONE:
- done=1, in_ready=0.
- MAR holds MAX_ADDR and word_count holds MAX_ADDR+1.
- start restarts the fill exactly as from IDLE; done drops on the next cycle.

Timing and handshake rules:
- Throughput: at most one word per 3 cycles. Handshake-to-write latency is exactly 1 cycle.
- in_valid and in_data are ignored whenever in_ready=0. A source holding in_valid high is not consumed early.
- start is ignored while busy=1.
- start and in_valid asserted together in IDLE: only start acts. The word is not captured until WAIT_DATA.
- Unused state encodings return to IDLE with all outputs deasserted.

Decomposition:
- Shared package, maxfinder_pkg:
  - state encoding constants for IDLE, WAIT_DATA, WRITE, CHECK_LAST, DONE as 3-bit values;
  - default DATA_W and ADDR_W constants, shared with the max-finder datapath.
- One natural sub-module, mem_loader_ctrl: the pure FSM.
  - Inputs: start, in_valid, mar_eq_maxaddr.
  - Outputs: en_mar, sel_mar, en_mdr, en_cnt, mem_we, in_ready, busy, done.
  - The top level holds the MAR/MDR/count registers and the comparator, mirroring the max-finder controller/datapath split.

Test Plan:
- Reset for 2 cycles, then idle 5 cycles -> all outputs 0, no mem_we pulse.
- start, then feed 16 words 0x10..0x1F with in_valid held high:
  - 16 mem_we pulses, addresses 0..15, data 0x10..0x1F in order;
  - done=1 after the 16th write; word_count=16; reading the RAM back matches.
- Same fill with in_valid gaps of 0-7 random cycles:
  - writes occur only after each handshake, one cycle later;
  - in_ready is never high in WRITE or CHECK_LAST;
  - the RAM contents are identical.
- MAX_ADDR=3, start pulsed repeatedly while busy -> the start pulses are ignored; exactly 4 writes; done holds; a second start in DONE rewrites addresses 0..3 with the new data.
- Assert reset after the 5th write, mid-WAIT_DATA -> next cycle all outputs are at reset values; no further mem_we.
- Integration: fill with 0x03,0x7F,0x12,... (max 0x7F at addr 1), then run the max-finder -> reported max = 0x7F.
